line_memctrl: RTL and testbench

LINE_MEMCTRL -- requirements
Module: line_memctrl

---
 rtl/line_memctrl.sv | 122 ++++++++++++
 tb/tb_line_memctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memctrl.sv
// line_memctrl: moves one 16-byte cache line between a requester and a byte-wide RAM.
// Writes stream one byte per cycle; reads overlap the next address with the previous byte's capture.
module line_memctrl #(
    parameter int LINE_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rdy,
    input  logic         wr_ena,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_line,
    input  logic         rd_ena,
    input  logic [31:0]  rd_addr,
    output logic [127:0] rd_line,
    output logic         valid,
    input  logic [7:0]   ram_din,
    output logic [7:0]   ram_dout,
    output logic [31:0]  ram_a,
    output logic         ram_wr,
    input  logic         io_buffer_full
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [4:0] LAST_BYTE = 5'(LINE_BYTES - 1);
    localparam logic [4:0] READ_DONE = 5'(LINE_BYTES);

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  base_q, base_d;
    logic         pend_q, pend_d;
    logic [127:0] rd_line_q, rd_line_d;

    logic [31:0]  cur_addr;
    logic [3:0]   cap_idx;
    logic         io_block;
    logic         wr_fire;
    logic         capture;
    logic         addr_phase;

    assign cur_addr   = base_q + {28'd0, cnt_q[3:0]};
    assign io_block   = io_buffer_full && (cur_addr[17:16] == 2'b11);
    assign wr_fire    = (state_q == WRITE) && rdy && !io_block;
    // pend_q means the address of byte cnt-1 was issued last cycle with rdy high,
    // so ram_din carries that byte now, even if rdy has since dropped.
    assign capture    = (state_q == READ) && pend_q;
    assign cap_idx    = cnt_q[3:0] - 4'd1;
    assign addr_phase = (state_q == WRITE) || ((state_q == READ) && (cnt_q != READ_DONE));

    assign ram_wr   = wr_fire;
    assign ram_a    = addr_phase ? cur_addr : 32'd0;
    assign ram_dout = (state_q == WRITE) ? wr_line[{cnt_q[3:0], 3'b000} +: 8] : 8'd0;
    assign valid    = (state_q == RESP) && rdy;
    assign rd_line  = rd_line_q;

    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
        assign rd_line_d[8*gi +: 8] = (capture && (cap_idx == 4'(gi))) ? ram_din
                                                                      : rd_line_q[8*gi +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy && wr_ena) begin
                    base_d  = wr_addr & 32'hFFFF_FFF0;
                    cnt_d   = 5'd0;
                    state_d = WRITE;
                end else if (rdy && rd_ena) begin
                    base_d  = rd_addr & 32'hFFFF_FFF0;
                    cnt_d   = 5'd0;
                    state_d = READ;
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = 5'd0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            READ: begin
                if (rdy) begin
                    if (cnt_q == READ_DONE) begin
                        cnt_d   = 5'd0;
                        state_d = RESP;
                    end else begin
                        cnt_d  = cnt_q + 5'd1;
                        pend_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            base_q    <= 32'd0;
            pend_q    <= 1'b0;
            rd_line_q <= 128'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            pend_q    <= pend_d;
            rd_line_q <= rd_line_d;
        end
    end
endmodule

// File: tb/tb_line_memctrl.sv
// Bench for line_memctrl: byte RAM model plus a line-level reference of what each line should hold.
module tb_line_memctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         rdy;
    logic         wr_ena;
    logic [31:0]  wr_addr;
    logic [127:0] wr_line;
    logic         rd_ena;
    logic [31:0]  rd_addr;
    logic [127:0] rd_line;
    logic         valid;
    logic [7:0]   ram_din;
    logic [7:0]   ram_dout;
    logic [31:0]  ram_a;
    logic         ram_wr;
    logic         io_buffer_full;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]   ram [0:262143];
    logic [39:0]  wlog [0:1023];
    int           wlog_n = 0;
    int           valid_n = 0;

    logic [127:0] ref_line [int unsigned];
    int unsigned  written [$];

    always #5 clk = ~clk;

    line_memctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_line(wr_line),
        .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_line(rd_line), .valid(valid),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM: one-cycle read latency; every write is logged in order.
    always @(posedge clk) begin
        ram_din <= ram[ram_a[17:0]];
        if (ram_wr === 1'b1) begin
            ram[ram_a[17:0]] <= ram_dout;
            if (wlog_n < 1024) begin
                wlog[wlog_n] <= {ram_a, ram_dout};
                wlog_n <= wlog_n + 1;
            end
        end
        if (valid === 1'b1) valid_n <= valid_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_write(input logic [31:0] addr, input logic [127:0] line);
        if (!ref_line.exists(addr >> 4)) written.push_back(addr & 32'hFFFF_FFF0);
        ref_line[addr >> 4] = line;
    endfunction

    // Drives one request and observes it; mode 1 drops rdy, mode 2 raises io_buffer_full,
    // over cycles s..s+len-1 counted from the sampling edge (cycle 1 follows it).
    task automatic run_xfer(input bit is_wr, input logic [31:0] addr, input logic [127:0] line,
                            input int mode, input int s, input int len,
                            output int lat, output int viol, output logic v_after,
                            output logic [127:0] line_at_valid);
        int cyc;
        lat = 0; viol = 0; cyc = 0; v_after = 1'b0; line_at_valid = '0;
        if (is_wr) begin
            wr_addr = addr; wr_line = line; wr_ena = 1'b1;
        end else begin
            rd_addr = addr; rd_ena = 1'b1;
        end
        while (lat == 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            rdy = !(mode == 1 && cyc >= s && cyc < s + len);
            io_buffer_full = (mode == 2 && cyc >= s && cyc < s + len);
            #1;
            if (ram_wr === 1'b1 && (!rdy || (io_buffer_full && addr[17:16] == 2'b11))) viol++;
            if (valid === 1'b1) begin
                lat = cyc;
                line_at_valid = rd_line;
            end
        end
        wr_ena = 1'b0; rd_ena = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        @(posedge clk);
        #2;
        v_after = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; wr_ena = 1'b1; rd_ena = 1'b0; io_buffer_full = 1'b0;
        wr_addr = 32'h0000_1000; wr_line = '1; rd_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++; if (ram_wr !== 1'b0) begin tests_failed++; $display("FAIL rst_ram_wr: got %b expected 0", ram_wr); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", valid); end
        tests_run++; if (ram_a !== 32'd0) begin tests_failed++; $display("FAIL rst_ram_a: got %h expected 0", ram_a); end
        tests_run++; if (ram_dout !== 8'd0) begin tests_failed++; $display("FAIL rst_ram_dout: got %h expected 0", ram_dout); end
        tests_run++; if (rd_line !== 128'd0) begin tests_failed++; $display("FAIL rst_rd_line: got %h expected 0", rd_line); end
        wr_ena = 1'b0; rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_write_basic();
        logic [127:0] line, rd_before, lv;
        int n0, lat, viol;
        logic v_after;
        for (int k = 0; k < 16; k++) line[8*k +: 8] = 8'(k);
        rd_before = rd_line;
        n0 = wlog_n;
        run_xfer(1'b1, 32'h0000_1238, line, 0, 0, 0, lat, viol, v_after, lv);
        tests_run++; if (lat !== 17) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 17", lat); end
        tests_run++; if (wlog_n - n0 !== 16) begin tests_failed++; $display("FAIL wr_count: got %0d expected 16", wlog_n - n0); end
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (wlog[n0 + k] !== {32'h1230 + 32'(k), 8'(k)}) begin
                tests_failed++;
                $display("FAIL wr_byte%0d: got %h expected %h", k, wlog[n0 + k], {32'h1230 + 32'(k), 8'(k)});
            end
        end
        tests_run++; if (v_after !== 1'b0) begin tests_failed++; $display("FAIL wr_valid_width: got %b expected 0", v_after); end
        tests_run++; if (rd_line !== rd_before) begin tests_failed++; $display("FAIL wr_rd_line_hold: got %h expected %h", rd_line, rd_before); end
        ref_write(32'h0000_1238, line);
    endtask

    task automatic test_read_basic();
        logic [127:0] line, lv;
        int n0, lat, viol;
        logic v_after;
        for (int k = 0; k < 16; k++) line[8*k +: 8] = 8'(8'hA0 + k);
        run_xfer(1'b1, 32'h0000_2000, line, 0, 0, 0, lat, viol, v_after, lv);
        ref_write(32'h0000_2000, line);
        n0 = wlog_n;
        run_xfer(1'b0, 32'h0000_2004, '0, 0, 0, 0, lat, viol, v_after, lv);
        tests_run++; if (lat !== 18) begin tests_failed++; $display("FAIL rd_latency: got %0d expected 18", lat); end
        tests_run++; if (lv !== 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0) begin tests_failed++; $display("FAIL rd_line: got %h expected %h", lv, 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0); end
        tests_run++; if (rd_line !== lv) begin tests_failed++; $display("FAIL rd_line_hold: got %h expected %h", rd_line, lv); end
        tests_run++; if (wlog_n !== n0) begin tests_failed++; $display("FAIL rd_no_write: got %0d writes expected 0", wlog_n - n0); end
        tests_run++; if (v_after !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_width: got %b expected 0", v_after); end
    endtask

    task automatic test_priority();
        logic [127:0] line, got;
        int n0, v0, cyc, pulses, second_at;
        line = {$urandom, $urandom, $urandom, $urandom};
        n0 = wlog_n; cyc = 0; pulses = 0; second_at = 0; got = '0;
        wr_addr = 32'h0000_4560; wr_line = line; rd_addr = 32'h0000_4568;
        wr_ena = 1'b1; rd_ena = 1'b1;
        while (pulses < 2 && cyc < 120) begin
            @(posedge clk);
            cyc++;
            #2;
            if (valid === 1'b1) begin
                pulses++;
                if (pulses == 1) wr_ena = 1'b0;
                if (pulses == 2) begin
                    rd_ena = 1'b0;
                    second_at = cyc;
                    got = rd_line;
                end
            end
        end
        wr_ena = 1'b0; rd_ena = 1'b0;
        ref_write(32'h0000_4560, line);
        v0 = valid_n;
        repeat (6) @(posedge clk);
        #2;
        tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL prio_pulses: got %0d expected 2", pulses); end
        tests_run++; if (second_at !== 36) begin tests_failed++; $display("FAIL prio_read_cycle: got %0d expected 36", second_at); end
        tests_run++; if (wlog_n - n0 !== 16) begin tests_failed++; $display("FAIL prio_writes: got %0d expected 16", wlog_n - n0); end
        tests_run++; if (got !== line) begin tests_failed++; $display("FAIL prio_read_data: got %h expected %h", got, line); end
        tests_run++; if (valid_n - v0 !== 1) begin tests_failed++; $display("FAIL prio_extra_valid: got %0d expected 1", valid_n - v0); end
    endtask

    task automatic test_stall();
        logic [127:0] line, lv;
        int n0, lat, viol, bad;
        logic v_after;
        logic [39:0] bad_got, bad_exp;
        run_xfer(1'b0, 32'h0000_2000, '0, 1, 6, 3, lat, viol, v_after, lv);
        tests_run++; if (lat !== 21) begin tests_failed++; $display("FAIL stall_rd_latency: got %0d expected 21", lat); end
        tests_run++; if (lv !== ref_line[32'h200]) begin tests_failed++; $display("FAIL stall_rd_line: got %h expected %h", lv, ref_line[32'h200]); end
        line = {$urandom, $urandom, $urandom, $urandom};
        n0 = wlog_n;
        run_xfer(1'b1, 32'h0003_0000, line, 2, 5, 4, lat, viol, v_after, lv);
        ref_write(32'h0003_0000, line);
        bad = 0; bad_got = '0; bad_exp = '0;
        for (int k = 0; k < 16; k++) begin
            if (wlog[n0 + k] !== {32'h0003_0000 + 32'(k), line[8*k +: 8]} && bad == 0) begin
                bad = 1; bad_got = wlog[n0 + k]; bad_exp = {32'h0003_0000 + 32'(k), line[8*k +: 8]};
            end
        end
        tests_run++; if (lat !== 21) begin tests_failed++; $display("FAIL stall_wr_latency: got %0d expected 21", lat); end
        tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL stall_wr_blocked: got %0d writes expected 0", viol); end
        tests_run++; if (wlog_n - n0 !== 16) begin tests_failed++; $display("FAIL stall_wr_count: got %0d expected 16", wlog_n - n0); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL stall_wr_data: got %h expected %h", bad_got, bad_exp); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit is_wr;
            int mode, s, len, exp_lat, n0, lat, viol, bad;
            logic [31:0] addr;
            logic [127:0] line, lv, exp_line, rd_before;
            logic v_after;
            is_wr = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            s = $urandom_range(1, 12);
            len = $urandom_range(1, 4);
            line = {$urandom, $urandom, $urandom, $urandom};
            if (is_wr)
                addr = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            else
                addr = written[$urandom_range(0, written.size() - 1)] | 32'($urandom_range(0, 15));
            exp_lat = is_wr ? 17 : 18;
            if (mode == 1 || (mode == 2 && is_wr && addr[17:16] == 2'b11)) exp_lat += len;
            exp_line = is_wr ? '0 : ref_line[addr >> 4];
            rd_before = rd_line;
            n0 = wlog_n;
            run_xfer(is_wr, addr, line, mode, s, len, lat, viol, v_after, lv);
            tests_run++; if (lat !== exp_lat) begin tests_failed++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat); end
            tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL rand%0d_stalled_write: got %0d expected 0", it, viol); end
            tests_run++; if (v_after !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_valid_width: got %b expected 0", it, v_after); end
            if (is_wr) begin
                bad = 0;
                for (int k = 0; k < 16; k++)
                    if (wlog[n0 + k] !== {(addr & 32'hFFFF_FFF0) + 32'(k), line[8*k +: 8]}) bad++;
                tests_run++; if (wlog_n - n0 !== 16 || bad != 0) begin tests_failed++; $display("FAIL rand%0d_writes: got %0d writes %0d wrong expected 16 writes 0 wrong", it, wlog_n - n0, bad); end
                tests_run++; if (rd_line !== rd_before) begin tests_failed++; $display("FAIL rand%0d_rd_line_hold: got %h expected %h", it, rd_line, rd_before); end
                ref_write(addr, line);
            end else begin
                tests_run++; if (lv !== exp_line) begin tests_failed++; $display("FAIL rand%0d_rd_line: got %h expected %h", it, lv, exp_line); end
                tests_run++; if (wlog_n !== n0) begin tests_failed++; $display("FAIL rand%0d_rd_no_write: got %0d expected 0", it, wlog_n - n0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0, v0;
        wr_addr = 32'h0000_5670; wr_line = {$urandom, $urandom, $urandom, $urandom}; wr_ena = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        tests_run++; if (ram_wr !== 1'b1 || ram_a !== 32'h0000_5677) begin tests_failed++; $display("FAIL midrst_pre: got wr=%b a=%h expected wr=1 a=00005677", ram_wr, ram_a); end
        rst_n = 1'b0; wr_ena = 1'b0;
        @(posedge clk);
        #2;
        tests_run++; if (ram_wr !== 1'b0) begin tests_failed++; $display("FAIL midrst_ram_wr: got %b expected 0", ram_wr); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b expected 0", valid); end
        tests_run++; if (ram_a !== 32'd0) begin tests_failed++; $display("FAIL midrst_idle_addr: got %h expected 0", ram_a); end
        tests_run++; if (rd_line !== 128'd0) begin tests_failed++; $display("FAIL midrst_rd_line: got %h expected 0", rd_line); end
        rst_n = 1'b1;
        n0 = wlog_n; v0 = valid_n;
        repeat (30) @(posedge clk);
        #2;
        tests_run++; if (wlog_n !== n0) begin tests_failed++; $display("FAIL midrst_writes: got %0d expected 0", wlog_n - n0); end
        tests_run++; if (valid_n !== v0) begin tests_failed++; $display("FAIL midrst_pulses: got %0d expected 0", valid_n - v0); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_priority();
        test_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
